// File: rtl/mdu_defs.sv
// Shared encodings for the EX-stage multiply/divide unit, its decoder and the hazard unit.
package mdu_defs;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;

  // keep = divide by zero: HI/LO are left untouched at commit
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        keep;
  } md_res_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational HI/LO result for MULT/MULTU/DIV/DIVU, including sign and divide-by-zero rules.
module md_arith
  import mdu_defs::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output md_res_t     res_o
);

  logic        sgn_mul, sgn_div;
  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  // Product of the two 64-bit extended operands, truncated to 64 bits, is the exact signed/unsigned product
  assign sgn_mul = (op_i == MD_MULT);
  assign a_ext   = sgn_mul ? {{32{a_i[31]}}, a_i} : {32'd0, a_i};
  assign b_ext   = sgn_mul ? {{32{b_i[31]}}, b_i} : {32'd0, b_i};
  assign prod    = a_ext * b_ext;

  // Signed divide via magnitudes; -2^31 / -1 falls out as 0x80000000 rem 0
  assign sgn_div = (op_i == MD_DIV);
  assign a_neg   = sgn_div & a_i[31];
  assign b_neg   = sgn_div & b_i[31];
  assign a_mag   = a_neg ? (32'd0 - a_i) : a_i;
  assign b_mag   = b_neg ? (32'd0 - b_i) : b_i;
  assign b_zero  = (b_i == 32'd0);
  assign b_safe  = b_zero ? 32'd1 : b_mag;
  assign q_mag   = a_mag / b_safe;
  assign r_mag   = a_mag % b_safe;
  assign quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem     = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    res_o = '0;
    case (op_i)
      MD_MULT, MD_MULTU: begin
        res_o.hi = prod[63:32];
        res_o.lo = prod[31:0];
      end
      MD_DIV, MD_DIVU: begin
        if (b_zero) begin
          res_o.keep = 1'b1;
        end else begin
          res_o.hi = rem;
          res_o.lo = quot;
        end
      end
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, runs fixed-latency MULT/DIV and flags runMulOrDiv to the hazard unit.
module mul_div_unit
  import mdu_defs::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdOp,
  input  logic        mdStart,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic        runMulOrDiv,
  output logic [31:0] hiOut,
  output logic [31:0] loOut,
  output logic [31:0] mdReadData
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q;
  logic [31:0]      hi_q, lo_q;
  md_res_t          pend_q, arith_res;
  logic             start_mc;

  md_arith u_arith (
    .op_i  (mdOp),
    .a_i   (srcA),
    .b_i   (srcB),
    .res_o (arith_res)
  );

  assign start_mc = mdStart & is_multicycle(mdOp);
  assign cnt_d    = is_mul(mdOp) ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);

  // Result is latched at accept so the operands need not be held while busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_mc) begin
            pend_q  <= arith_res;
            cnt_q   <= cnt_d;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end else if (mdStart && (mdOp == MD_MTHI)) begin
            hi_q <= srcA;
          end else if (mdStart && (mdOp == MD_MTLO)) begin
            lo_q <= srcA;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (!pend_q.keep) begin
              hi_q <= pend_q.hi;
              lo_q <= pend_q.lo;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign runMulOrDiv = busy_q | start_mc;
  assign hiOut       = hi_q;
  assign loOut       = lo_q;

  always_comb begin
    mdReadData = '0;
    if (mdOp == MD_MFHI)      mdReadData = hi_q;
    else if (mdOp == MD_MFLO) mdReadData = lo_q;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboarded random + directed bench for mul_div_unit against a plain-arithmetic HI/LO model.
module tb_mul_div_unit;
  import mdu_defs::*;

  localparam int MULN = 5;
  localparam int DIVN = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mdOp;
  logic        mdStart;
  logic [31:0] srcA, srcB;
  logic        busy, runMulOrDiv;
  logic [31:0] hiOut, loOut, mdReadData;

  mul_div_unit #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
    .clk         (clk),
    .reset       (reset),
    .mdOp        (mdOp),
    .mdStart     (mdStart),
    .srcA        (srcA),
    .srcB        (srcB),
    .busy        (busy),
    .runMulOrDiv (runMulOrDiv),
    .hiOut       (hiOut),
    .loOut       (loOut),
    .mdReadData  (mdReadData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pend = '0;
  int          m_left = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic mc_op(input logic [3:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

  function automatic logic [63:0] ref_hilo(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] h,
                                           input logic [31:0] l);
    longint          x, y, q, r;
    longint unsigned ux, uy, up;
    case (op)
      MD_MULT: begin
        x = longint'($signed(a)); y = longint'($signed(b));
        q = x * y;
        return q;
      end
      MD_MULTU: begin
        ux = {32'd0, a}; uy = {32'd0, b};
        up = ux * uy;
        return up;
      end
      MD_DIV: begin
        if (b == 0) return {h, l};
        x = longint'($signed(a)); y = longint'($signed(b));
        q = x / y; r = x % y;
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (b == 0) return {h, l};
        ux = {32'd0, a}; uy = {32'd0, b};
        return {32'(ux % uy), 32'(ux / uy)};
      end
      default: return {h, l};
    endcase
  endfunction

  // One cycle of stimulus, entered and left at posedge+1
  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic st);
    logic [31:0] rd;
    exp_t        e;
    mdOp = op; srcA = a; srcB = b; mdStart = st;
    #1;
    rd = (op == MD_MFHI) ? m_hi : (op == MD_MFLO) ? m_lo : 32'd0;
    chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
    chk("runMulOrDiv", {31'd0, runMulOrDiv}, {31'd0, (m_left > 0) || (st && mc_op(op))});
    chk("mdReadData", mdReadData, rd);
    @(posedge clk);
    if (m_left > 0) begin
      if (st && mc_op(op)) $display("note: protocol violation, start while busy ignored at %0t", $time);
      m_left--;
      if (m_left == 0) {m_hi, m_lo} = m_pend;
    end else if (st && mc_op(op)) begin
      m_pend = ref_hilo(op, a, b, m_hi, m_lo);
      m_left = (op == MD_MULT || op == MD_MULTU) ? MULN : DIVN;
      e.hi = m_pend[63:32]; e.lo = m_pend[31:0]; e.len = m_left;
      sbq.push_back(e);
    end else if (st && op == MD_MTHI) begin
      m_hi = a;
    end else if (st && op == MD_MTLO) begin
      m_lo = a;
    end
    #1;
    chk("hiOut", hiOut, m_hi);
    chk("loOut", loOut, m_lo);
  endtask

  task automatic idle_until_done();
    for (int i = 0; i < 40 && m_left > 0; i++) step(MD_NONE, 32'd0, 32'd0, 1'b0);
  endtask

  // Monitor: each busy run ends in a commit that must match the next queued result
  initial begin
    int   run;
    exp_t e;
    run = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        run = 0;
      end else if (busy) begin
        run++;
      end else if (run > 0) begin
        if (sbq.size() == 0) begin
          chk("unexpected_commit", 32'(run), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("busy_len", 32'(run), 32'(e.len));
          chk("commit_hi", hiOut, e.hi);
          chk("commit_lo", loOut, e.lo);
        end
        run = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    reset = 1'b0; mdOp = MD_NONE; mdStart = 1'b0; srcA = '0; srcB = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hiOut, 32'd0);
    chk("rst_lo", loOut, 32'd0);
    chk("rst_run", {31'd0, runMulOrDiv}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    step(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
    idle_until_done();
    chk("mult_hi", hiOut, 32'hFFFF_FFFF);
    chk("mult_lo", loOut, 32'hFFFF_FFFA);
    step(MD_MFLO, 32'd0, 32'd0, 1'b1);

    step(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    idle_until_done();
    chk("div_hi", hiOut, 32'hFFFF_FFFF);
    chk("div_lo", loOut, 32'hFFFF_FFFD);
    step(MD_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b1);
    idle_until_done();
    chk("divu_hi", hiOut, 32'd1);
    chk("divu_lo", loOut, 32'h7FFF_FFFC);
    step(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    idle_until_done();
    chk("divovf_hi", hiOut, 32'd0);
    chk("divovf_lo", loOut, 32'h8000_0000);

    step(MD_MTHI, 32'h1234, 32'd0, 1'b1);
    step(MD_MTLO, 32'h5678, 32'd0, 1'b1);
    step(MD_DIVU, 32'd5, 32'd0, 1'b1);
    idle_until_done();
    chk("div0_hi", hiOut, 32'h1234);
    chk("div0_lo", loOut, 32'h5678);

    step(MD_MULT, 32'd7, 32'd9, 1'b1);
    step(MD_NONE, 32'd0, 32'd0, 1'b0);
    step(MD_MULT, 32'd2, 32'd2, 1'b1);
    idle_until_done();
    chk("ignored_hi", hiOut, 32'd0);
    chk("ignored_lo", loOut, 32'd63);

    step(MD_DIV, 32'd100, 32'd7, 1'b1);
    step(MD_NONE, 32'd0, 32'd0, 1'b0);
    step(MD_NONE, 32'd0, 32'd0, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hiOut, 32'd0);
    chk("midrst_lo", loOut, 32'd0);
    sbq.delete();
    m_left = 0; m_hi = '0; m_lo = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (DIVN + 2) step(MD_NONE, 32'd0, 32'd0, 1'b0);
    step(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    idle_until_done();
    chk("multu_hi", hiOut, 32'hFFFF_FFFE);
    chk("multu_lo", loOut, 32'h0000_0001);

    step(MD_MULTU, 32'd3, 32'd4, 1'b1);
    repeat (MULN) step(MD_NONE, 32'd0, 32'd0, 1'b0);
    step(MD_MTHI, 32'hAAAA, 32'd0, 1'b1);
    step(MD_NONE, 32'd0, 32'd0, 1'b0);
    chk("b2b_hi", hiOut, 32'hAAAA);
    chk("b2b_lo", loOut, 32'd12);

    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(1, 8));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
      step(op, a, b, 1'b1);
      idle_until_done();
    end
    step(MD_MFHI, 32'd0, 32'd0, 1'b1);
    step(MD_MFLO, 32'd0, 32'd0, 1'b1);
    repeat (2) step(MD_NONE, 32'd0, 32'd0, 1'b0);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- EX-stage multiply/divide unit owning the HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO.
- Runs multi-cycle operations with a fixed latency and drives runMulOrDiv. The hazard/stall unit uses runMulOrDiv to stall any mul/div-class instruction held in ID.
- Also supplies the MFHI/MFLO read value to the EX result mux.

Parameters:
- MUL_CYCLES, 5, busy cycles after a MULT/MULTU start (≥1).
- DIV_CYCLES, 10, busy cycles after a DIV/DIVU start (≥1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted); deassertion synchronous to clk.
- mdOp  in  4  operation code from the shared package; MD_NONE = 0.
- mdStart  in  1  EX holds a valid mul/div-class instruction this cycle.
- srcA  in  32  forwarded rs value.
- srcB  in  32  forwarded rt value.
- busy  out  1  registered; 1 while a MULT/DIV is in progress.
- runMulOrDiv  out  1  combinational: busy OR (mdStart AND mdOp is MULT/MULTU/DIV/DIVU); goes to the hazard unit.
- hiOut  out  32  current HI register.
- loOut  out  32  current LO register.
- mdReadData  out  32  HI when mdOp = MD_MFHI, LO when mdOp = MD_MFLO, else 0.

Behaviour:
- Reset (reset = 0, async): state IDLE, counter 0, busy 0, HI 0, LO 0, pending result cleared. Reset mid-operation discards the result; HI/LO read 0 afterwards.
- States:
  - IDLE → BUSY on an accepted start of MULT/MULTU/DIV/DIVU.
  - BUSY → IDLE when the counter reaches 1.
- Accept rule:
  - A start is accepted only in IDLE with mdStart = 1.
  - On the accept edge: latch the full result into pendingHi/pendingLo; load the counter with MUL_CYCLES or DIV_CYCLES; set busy.
- Count and commit:
  - The counter decrements every cycle in BUSY.
  - On the edge where it goes 1 → 0: HI/LO ← pending, busy ← 0.
- Latency: start in cycle T → busy = 1 in cycles T+1 … T+N → new HI/LO visible from cycle T+N+1.
- Arithmetic:
  - MULT: signed 32×32 → 64; HI = [63:32], LO = [31:0].
  - MULTU: unsigned 32×32 → 64, same split.
  - DIV: signed; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned; LO = quotient, HI = remainder.
  - DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divide by zero (DIV or DIVU): operation still runs the full DIV_CYCLES with busy asserted; HI and LO remain unchanged at commit.
- MTHI/MTLO:
  - Single-cycle; accepted only in IDLE.
  - HI (resp. LO) ← srcA on the edge of the cycle with mdStart = 1. busy is never set.
- MFHI/MFLO: combinational read of the current HI/LO; no state change.
- Start while BUSY: ignored, with no state change. The hazard unit guarantees this never happens; the bench flags it as a protocol violation.
- Simultaneous events:
  - Commit edge and a new start in the same cycle cannot occur, because runMulOrDiv is still 1 in the commit cycle.
  - A start in the first IDLE cycle after commit is legal.
- Pipeline flush: no flush input. A start is only issued by an instruction already committed to EX, so the operation always completes.

Decomposition:
- Shared package (mdu_defs):
  - mdOp encodings: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO.
  - State encodings: IDLE, BUSY.
  - Default cycle counts.
- Control decoder: drives mdOp/mdStart, and the hazard unit's toMulOrDiv from the same encodings.
- Sub-module md_arith: purely combinational. Computes the 64-bit {hi, lo} result from op, srcA and srcB, including the sign and divide-by-zero rules. mul_div_unit keeps the FSM, counter and registers.

Test Plan:
- MULT srcA = 0xFFFFFFFE (−2), srcB = 3, start at cycle T → runMulOrDiv = 1 in T; busy = 1 in T+1…T+5. From T+6: HI = 0xFFFFFFFF, LO = 0xFFFFFFFA; MFLO returns 0xFFFFFFFA.
- DIV srcA = 0xFFFFFFF9 (−7), srcB = 2 → busy for 10 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU with the same operands → LO = 0x7FFFFFFC, HI = 1.
- Divide by zero: MTHI 0x1234, MTLO 0x5678, then DIVU srcA = 5, srcB = 0 → busy 10 cycles; HI = 0x1234 and LO = 0x5678 unchanged.
- Start of MULT 2×2 at cycle T+2 during a prior MULT → ignored. After commit, HI/LO hold only the first result, and the bench reports a protocol violation.
- Assert reset = 0 at cycle T+3 of a DIV → busy = 0 and HI = LO = 0 immediately. After release, no commit occurs and a new MULTU 0xFFFFFFFF × 0xFFFFFFFF yields HI = 0xFFFFFFFE, LO = 0x00000001.
- Back-to-back: MULTU 3×4 committing at T+6, MTHI 0xAAAA at T+6 → HI = 0xAAAA, LO = 12, busy = 0 throughout the MTHI.
